// File: rtl/vga_sync.sv
// vga_sync: 640x480@60 raster timing with RGB332 output and a
// read-latency delay line. Optional colour bars: VGA_TEST_PATTERN_EN.
module vga_sync #(
    parameter int bitsPixel     = 8,
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [bitsPixel-1:0] i_pixel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                 i_pattern,
`endif
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic [2:0]           o_red,
    output logic [2:0]           o_green,
    output logic [1:0]           o_blue,
    output logic                 o_pixel_en,
    output logic                 o_active,
    output logic [9:0]           o_x,
    output logic [9:0]           o_y,
    output logic                 o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay word: [0]=active [1]=hs [2]=vs, plus [3]=pattern [6:4]=bar.
`ifdef VGA_TEST_PATTERN_EN
    localparam int DW = 7;
`else
    localparam int DW = 3;
`endif
    localparam logic [DW-1:0] DL_RST = DW'(3'b110);

    logic          r_pix_en;
    logic [9:0]    r_h;
    logic [9:0]    r_v;
    logic          w_active0;
    logic          w_hs0;
    logic          w_vs0;
    logic [DW-1:0] w_s0;
    logic [DW-1:0] w_sd;
    logic          r_hsync;
    logic          r_vsync;
    logic [2:0]    r_red;
    logic [2:0]    r_green;
    logic [1:0]    r_blue;
    logic [2:0]    w_red;
    logic [2:0]    w_green;
    logic [1:0]    w_blue;

    // Divide-by-2 pixel enable; low in the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    // Raster counters; out-of-range values fall back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_pix_en) begin
            if (r_h >= H_LAST) begin
                r_h <= '0;
                if (r_v >= V_LAST) begin
                    r_v <= '0;
                end else begin
                    r_v <= r_v + 10'd1;
                end
            end else begin
                r_h <= r_h + 10'd1;
                if (r_v > V_LAST) begin
                    r_v <= '0;
                end
            end
        end
    end

    assign w_active0 = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs0     = !((r_h >= HS_BEG) && (r_h < HS_END));
    assign w_vs0     = !((r_v >= VS_BEG) && (r_v < VS_END));

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar;

    // Bar index: eight 80-pixel columns across the visible line.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h >= 10'(k * 80)) begin
                w_bar = 3'(k);
            end
        end
    end

    assign w_s0 = {w_bar, i_pattern, w_vs0, w_hs0, w_active0};
`else
    assign w_s0 = {w_vs0, w_hs0, w_active0};
`endif

    generate
        if (PIXEL_LATENCY == 0) begin : g_nodl
            assign w_sd = w_s0;
        end else begin : g_dl
            logic [DW-1:0] r_dl [PIXEL_LATENCY];

            // Clk-rate shift line matching the frame-buffer read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        r_dl[i] <= DL_RST;
                    end
                end else begin
                    r_dl[0] <= w_s0;
                    for (int i = 1; i < PIXEL_LATENCY; i++) begin
                        r_dl[i] <= r_dl[i-1];
                    end
                end
            end

            assign w_sd = r_dl[PIXEL_LATENCY-1];
        end
    endgenerate

    // Colour source: frame-buffer pixel, or a bar when the pattern is on.
    always_comb begin
        w_red   = i_pixel[7:5];
        w_green = i_pixel[4:2];
        w_blue  = i_pixel[1:0];
`ifdef VGA_TEST_PATTERN_EN
        if (w_sd[3]) begin
            w_red   = {3{w_sd[6]}};
            w_green = {3{w_sd[5]}};
            w_blue  = {2{w_sd[4]}};
        end
`endif
    end

    // Pin register, updated every clk so each pixel is held 2 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hsync <= w_sd[1];
            r_vsync <= w_sd[2];
            if (w_sd[0]) begin
                r_red   <= w_red;
                r_green <= w_green;
                r_blue  <= w_blue;
            end else begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
            end
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_pixel_en    = r_pix_en;
    assign o_active      = w_active0;
    assign o_x           = w_active0 ? r_h : 10'd0;
    assign o_y           = w_active0 ? r_v : 10'd0;
    assign o_frame_start = r_pix_en && (r_h == 10'd0) && (r_v == 10'd0);

endmodule
